audio_out_pacer: RTL and testbench

Downstream consumer of the PSOLA ring-buffer audio stream. Absorbs bursty 32-bit signed audio words into a small FIFO and releases exactly one word per sample period. Each released word is shifted and saturated to signed 16-bit, then rendered as a PWM DAC output. Also exposes the 16-bit sample with a strobe for an I2S/debug tap.

---
 rtl/audio_out_pacer.sv | 143 ++++++++++++++
 tb/tb_audio_out_pacer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_out_pacer.sv
// Paces a bursty 32-bit audio stream out at one word per sample period, saturates
// it to signed 16 bits and renders it on a PWM DAC. Optional feature: DITHER_EN.
module audio_out_pacer #(
    parameter int FIFO_DEPTH    = 16,
    parameter int SAMPLE_PERIOD = 2304,
    parameter int PRIME_LEVEL   = 4,
    parameter int SHIFT         = 8,
    parameter int PWM_BITS      = 8
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [31:0]                   audio_in,
    input  logic                          audio_valid_in,
    output logic [15:0]                   sample_out,
    output logic                          sample_strobe_out,
    output logic                          pwm_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
    output logic                          overflow_out,
    output logic                          underflow_out
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_PRIME = LVL_W'(PRIME_LEVEL);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SAMPLE_PERIOD - 1);

    typedef enum logic {ST_PRIMING, ST_RUNNING} state_t;

    state_t              r_state, w_state_nxt;
    logic [31:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [LVL_W-1:0]    r_level;
    logic [CNT_W-1:0]    r_tick_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt, r_duty;

    logic                w_tick, w_pop, w_push, w_underflow;
    logic [31:0]         w_head, w_word;
    logic signed [31:0]  w_shifted;
    logic [15:0]         w_sat, w_offset;
    logic [PWM_BITS-1:0] w_duty_new, w_duty;

    assign w_tick      = (r_tick_cnt == CNT_LAST);
    assign w_pop       = w_tick && (r_state == ST_RUNNING) && (r_level != '0);
    assign w_underflow = w_tick && (r_state == ST_RUNNING) && (r_level == '0);
    // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
    assign w_push      = audio_valid_in && ((r_level != LVL_FULL) || w_pop);
    assign w_head      = r_mem[r_rd_ptr];

`ifdef DITHER_EN
    localparam logic [31:0] DITHER_MASK = (32'd1 << SHIFT) - 32'd1;
    logic [15:0] r_lfsr;
    logic [32:0] w_sum;

    // Dither only ever adds a non-negative value, so only positive overflow can occur.
    assign w_sum  = {w_head[31], w_head} + {1'b0, ({16'h0, r_lfsr} & DITHER_MASK)};
    assign w_word = (!w_sum[32] && w_sum[31]) ? 32'h7FFF_FFFF : w_sum[31:0];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)  r_lfsr <= 16'hACE1;
        else if (w_tick) r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
`else
    assign w_word = w_head;
`endif

    assign w_shifted = $signed(w_word) >>> SHIFT;

    always_comb begin
        if (w_shifted > 32'sd32767)        w_sat = 16'h7FFF;
        else if (w_shifted < -32'sd32768)  w_sat = 16'h8000;
        else                               w_sat = w_shifted[15:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_PRIMING: if (r_level >= LVL_PRIME) w_state_nxt = ST_RUNNING;
            ST_RUNNING: if (w_underflow)          w_state_nxt = ST_PRIMING;
            default:                              w_state_nxt = ST_PRIMING;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= ST_PRIMING;
            r_tick_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_level    <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
        end
    end

    // NOTE: the storage array has no reset; the pointers and level alone define what is valid.
    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wr_ptr] <= audio_in;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sample_out        <= '0;
            sample_strobe_out <= 1'b0;
            overflow_out      <= 1'b0;
            underflow_out     <= 1'b0;
        end else begin
            sample_strobe_out <= w_tick;
            overflow_out      <= audio_valid_in && !w_push;
            underflow_out     <= w_underflow;
            if (w_tick) begin
                if (r_state == ST_PRIMING) sample_out <= '0;
                else if (w_pop)            sample_out <= w_sat;
            end
        end
    end

    // Offset-binary duty, captured at the counter wrap so a period is never split.
    assign w_offset   = sample_out ^ 16'h8000;
    assign w_duty_new = w_offset[15 -: PWM_BITS];
    assign w_duty     = (r_pwm_cnt == '0) ? w_duty_new : r_duty;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pwm_cnt <= '0;
            r_duty    <= '0;
            pwm_out   <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            if (r_pwm_cnt == '0) r_duty <= w_duty_new;
            pwm_out   <= (r_pwm_cnt < w_duty);
        end
    end

    assign fifo_level_out = r_level;

endmodule

// File: tb/tb_audio_out_pacer.sv
// Scoreboard bench for audio_out_pacer: a queue-based reference model predicts each
// edge's outputs; a negedge monitor pops and compares them.
module tb_audio_out_pacer;

    localparam int DEPTH  = 16;
    localparam int PERIOD = 8;
    localparam int PRIME  = 4;
    localparam int SHIFT  = 8;
    localparam int PWMB   = 8;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [31:0] audio_in = 32'h0;
    logic        audio_valid_in = 1'b0;
    logic [15:0] sample_out;
    logic        sample_strobe_out;
    logic        pwm_out;
    logic [4:0]  fifo_level_out;
    logic        overflow_out;
    logic        underflow_out;

    always #5 clk_in = ~clk_in;

    audio_out_pacer #(
        .FIFO_DEPTH(DEPTH), .SAMPLE_PERIOD(PERIOD), .PRIME_LEVEL(PRIME),
        .SHIFT(SHIFT), .PWM_BITS(PWMB)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .audio_in(audio_in),
        .audio_valid_in(audio_valid_in), .sample_out(sample_out),
        .sample_strobe_out(sample_strobe_out), .pwm_out(pwm_out),
        .fifo_level_out(fifo_level_out), .overflow_out(overflow_out),
        .underflow_out(underflow_out)
    );

    typedef struct packed {
        logic       strobe;
        logic       underflow;
        logic       overflow;
        logic       pwm;
        logic [4:0] level;
    } cyc_t;

    cyc_t        exp_q[$];
    logic [15:0] samp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    // Reference model state: the FIFO as a queue, time as a cycle index.
    logic [31:0] m_fifo[$];
    int          m_cnt;
    bit          m_running;
    logic [15:0] m_sample;
    int          m_pwm_cnt;
    int          m_duty;
`ifdef DITHER_EN
    logic [15:0] m_lfsr;
`endif

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] ref_sat(logic [31:0] w, int dith);
        longint v;
        v = longint'($signed(w)) + longint'(dith);
        if (v > 64'sd2147483647) v = 64'sd2147483647;
        v = v >>> SHIFT;
        if (v > 64'sd32767) v = 64'sd32767;
        else if (v < -64'sd32768) v = -64'sd32768;
        return v[15:0];
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        samp_q.delete();
        m_cnt     = 0;
        m_running = 0;
        m_sample  = 16'h0;
        m_pwm_cnt = 0;
        m_duty    = 0;
`ifdef DITHER_EN
        m_lfsr = 16'hACE1;
`endif
    endtask

    // Predict what the DUT shows after the next rising edge, given this cycle's input.
    task automatic model_step(bit v, logic [31:0] d);
        cyc_t        r;
        int          lvl_before, dith;
        bit          tick;
        logic [15:0] off;
        r          = '0;
        dith       = 0;
        lvl_before = m_fifo.size();
        tick       = (m_cnt == PERIOD - 1);
        m_cnt      = (m_cnt + 1) % PERIOD;
        if (m_pwm_cnt == 0) begin
            off    = m_sample ^ 16'h8000;
            m_duty = int'(off[15 -: PWMB]);
        end
        r.pwm     = (m_pwm_cnt < m_duty);
        m_pwm_cnt = (m_pwm_cnt + 1) % (1 << PWMB);
        if (tick) begin
`ifdef DITHER_EN
            dith   = int'(m_lfsr) % (1 << SHIFT);
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
`endif
            r.strobe = 1'b1;
            if (!m_running)          m_sample = 16'h0;
            else if (lvl_before > 0) m_sample = ref_sat(m_fifo.pop_front(), dith);
            else                     r.underflow = 1'b1;
            samp_q.push_back(m_sample);
        end
        if (m_running && tick && lvl_before == 0) m_running = 0;
        else if (!m_running && lvl_before >= PRIME) m_running = 1;
        if (v) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
            else r.overflow = 1'b1;
        end
        r.level = 5'(m_fifo.size());
        exp_q.push_back(r);
    endtask

    task automatic cycle(bit v, logic [31:0] d);
        audio_valid_in = v;
        audio_in       = v ? d : 32'h0;
        model_step(v, d);
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({sample_out, sample_strobe_out, pwm_out, fifo_level_out,
                    overflow_out, underflow_out});
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 4))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'($signed($urandom_range(0, 65535)) - 32768);
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk_in) begin
        cyc_t a, e;
        if (rst_n_in) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.strobe    = sample_strobe_out;
                a.underflow = underflow_out;
                a.overflow  = overflow_out;
                a.pwm       = pwm_out;
                a.level     = fifo_level_out;
                check("cycle_flags{strobe,unf,ovf,pwm,level}", 64'(a), 64'(e));
            end
            if (sample_strobe_out) begin
                if (samp_q.size() == 0) check("strobe_without_tick", 64'(sample_strobe_out), 64'd0);
                else check("sample", 64'(sample_out), 64'(samp_q.pop_front()));
            end
        end
    end

    initial begin
        int hi, k, guard;
        model_reset();
        #23;
        check("reset_outputs", all_outputs(), 64'd0);
        @(negedge clk_in);
        #1 rst_n_in = 1'b1;

        // Prime with four words: tick at edge 8 pops, so after edge 16 two words remain.
        repeat (4) cycle(1'b1, 32'h0000_1200);
        repeat (12) cycle(1'b0, 32'h0);
        check("first_running_sample", 64'(sample_out), 64'h0012);
        check("level_after_two_pops", 64'(fifo_level_out), 64'd2);

        // Saturation corners, then drain into an underflow.
        cycle(1'b1, 32'h7FFF_FFFF);
        cycle(1'b1, 32'h8000_0000);
        cycle(1'b1, 32'hFFFF_FF00);
        guard = 0;
        while (!underflow_out && guard < 200) begin
            cycle(1'b0, 32'h0);
            guard++;
        end
        check("underflow_seen", 64'(underflow_out), 64'd1);
        check("sample_held_on_underflow", 64'(sample_out), 64'hFFFF);
        check("level_empty_on_underflow", 64'(fifo_level_out), 64'd0);

        // Below the prime level playback must not restart.
        repeat (3) cycle(1'b1, rand_word());
        repeat (24) cycle(1'b0, 32'h0);
        check("still_priming_sample_zero", 64'(sample_out), 64'd0);
        cycle(1'b1, rand_word());

        // Back-to-back burst past full, then keep writing across pops while full.
        repeat (40) cycle(1'b1, rand_word());

        // Random traffic: first faster than the drain rate, then slower.
        repeat (600) cycle(($urandom_range(0, 5) == 0), rand_word());
        repeat (600) cycle(($urandom_range(0, 9) == 0), rand_word());

        // Idle until the sample is 0, then one aligned PWM window at half duty.
        repeat (200) cycle(1'b0, 32'h0);
        while (m_pwm_cnt != 0) cycle(1'b0, 32'h0);
        hi = 0;
        for (int i = 0; i < (1 << PWMB); i++) begin
            cycle(1'b0, 32'h0);
            hi += int'(pwm_out);
        end
        check("pwm_high_count_sample_0", 64'(hi), 64'd128);

        // Steady stream of full-scale negative words: duty 0, pwm stuck low.
        repeat (6) cycle(1'b1, 32'h8000_0000);
        k = 0;
        repeat (300) begin
            cycle((k % PERIOD) == 0, 32'h8000_0000);
            k++;
        end
        while (m_pwm_cnt != 0) begin
            cycle((k % PERIOD) == 0, 32'h8000_0000);
            k++;
        end
        hi = 0;
        for (int i = 0; i < (1 << PWMB); i++) begin
            cycle((k % PERIOD) == 0, 32'h8000_0000);
            k++;
            hi += int'(pwm_out);
        end
        check("pwm_high_count_sample_min", 64'(hi), 64'd0);
        check("running_sample_min", 64'(sample_out), 64'h8000);

        // Asynchronous reset between edges while running.
        #2 rst_n_in = 1'b0;
        #1;
        check("async_reset_outputs", all_outputs(), 64'd0);
        model_reset();
        audio_valid_in = 1'b0;
        audio_in       = 32'h0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        #1 rst_n_in = 1'b1;
        repeat (3) cycle(1'b1, rand_word());
        repeat (20) cycle(1'b0, 32'h0);
        check("post_reset_priming_sample", 64'(sample_out), 64'd0);
        check("post_reset_level", 64'(fifo_level_out), 64'd3);
        repeat (300) cycle(($urandom_range(0, 6) == 0), rand_word());
        repeat (200) cycle(1'b0, 32'h0);

        @(negedge clk_in);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
